vga_timing: RTL and testbench

- Generates raster timing for the Chip-8 video path: pixel coordinates, pixel-rate strobes and line/frame markers.
- Sits directly upstream of the display stage, which consumes pixelX/pixelY/pixelEnable/lineStart/frameStart. hsync/vsync go to the board VGA connector.
- Coordinates are signed 11-bit. Blanking occupies negative values, so downstream stages can pre-load at small negative pixelX (e.g. -4).

---
 rtl/vga_timing_if.sv | 23 ++
 rtl/vga_timing.sv | 129 ++++++++++++
 tb/tb_vga_timing.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle from vga_timing to the display stage and VGA connector.
//   pixelX/pixelY : signed 11-bit coordinates, blanking is negative
//   pixelEnable   : one-clk strobe per visible pixel
//   lineStart     : one-clk strobe at the first clk of every line
//   frameStart    : one-clk strobe at the first clk of every frame
//   hsync/vsync   : active-low sync to the board connector
interface vga_timing_if;
    logic signed [10:0] pixelX;
    logic signed [10:0] pixelY;
    logic               pixelEnable;
    logic               lineStart;
    logic               frameStart;
    logic               hsync;
    logic               vsync;

    modport master (
        output pixelX, pixelY, pixelEnable, lineStart, frameStart, hsync, vsync
    );

    modport slave (
        input  pixelX, pixelY, pixelEnable, lineStart, frameStart, hsync, vsync
    );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for the Chip-8 video path.
// Counts pixels and lines in signed coordinates where blanking is negative
// (front porch, sync, back porch, then active), so consumers can pre-load
// at small negative pixelX.
// Ports:
//   clk   : system clock
//   res_n : asynchronous active-low reset, returns to the top-left blanking corner
//   vga   : vga_timing_if.master (coordinates, strobes, syncs)
// Optional build macro VGA_SYNC_DELAY_EN: delays hsync/vsync by two clk through
// a register pipeline to line up with a registered colour path downstream.
module vga_timing #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic         clk,
    input  logic         res_n,
    vga_timing_if.master vga
);

    localparam int unsigned CW = 11;
    localparam int unsigned DW = 4;

    localparam int H_BLANK = int'(H_FP + H_SYNC + H_BP);
    localparam int V_BLANK = int'(V_FP + V_SYNC + V_BP);

    localparam logic [DW-1:0]        DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic signed [CW-1:0] H_START  = CW'(-H_BLANK);
    localparam logic signed [CW-1:0] H_LAST   = CW'(int'(H_ACTIVE) - 1);
    localparam logic signed [CW-1:0] V_START  = CW'(-V_BLANK);
    localparam logic signed [CW-1:0] V_LAST   = CW'(int'(V_ACTIVE) - 1);
    localparam logic signed [CW-1:0] HS_FIRST = CW'(-H_BLANK + int'(H_FP));
    localparam logic signed [CW-1:0] HS_LAST  = CW'(-H_BLANK + int'(H_FP + H_SYNC) - 1);
    localparam logic signed [CW-1:0] VS_FIRST = CW'(-V_BLANK + int'(V_FP));
    localparam logic signed [CW-1:0] VS_LAST  = CW'(-V_BLANK + int'(V_FP + V_SYNC) - 1);

    // Configuration sanity: the signed 11-bit range must hold the whole raster.
    if (H_BLANK + int'(H_ACTIVE) > 1024) begin : g_hCfgErr
        $error("vga_timing: H_BLANK+H_ACTIVE exceeds 1024");
    end
    if (V_BLANK + int'(V_ACTIVE) > 1024) begin : g_vCfgErr
        $error("vga_timing: V_BLANK+V_ACTIVE exceeds 1024");
    end
    if (CLK_DIV == 0 || CLK_DIV > 16) begin : g_divCfgErr
        $error("vga_timing: CLK_DIV outside 1..16");
    end

    logic [DW-1:0]        divCnt;
    logic [DW-1:0]        divNext;
    logic signed [CW-1:0] hCnt;
    logic signed [CW-1:0] hNext;
    logic signed [CW-1:0] vCnt;
    logic signed [CW-1:0] vNext;
    logic                 tick;
    logic                 firstClk;
    logic                 hsyncDec;
    logic                 vsyncDec;

    assign tick     = (divCnt == DIV_LAST);
    assign firstClk = (divCnt == '0);

    // Next-state for divider and raster counters; vCnt steps only on a line wrap.
    always_comb begin
        divNext = divCnt + DW'(1);
        hNext   = hCnt;
        vNext   = vCnt;
        if (tick) begin
            divNext = '0;
            if (hCnt == H_LAST) begin
                hNext = H_START;
                vNext = (vCnt == V_LAST) ? V_START : vCnt + CW'(1);
            end else begin
                hNext = hCnt + CW'(1);
            end
        end
    end

    // Counter state; reset lands on the top-left blanking corner.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            divCnt <= '0;
            hCnt   <= H_START;
            vCnt   <= V_START;
        end else begin
            divCnt <= divNext;
            hCnt   <= hNext;
            vCnt   <= vNext;
        end
    end

    // Strobes decode straight from state; gating on firstClk makes each one clk wide.
    assign vga.pixelX      = hCnt;
    assign vga.pixelY      = vCnt;
    assign vga.pixelEnable = firstClk && !hCnt[CW-1] && !vCnt[CW-1];
    assign vga.lineStart   = firstClk && (hCnt == H_START);
    assign vga.frameStart  = firstClk && (hCnt == H_START) && (vCnt == V_START);

    assign hsyncDec = !((hCnt >= HS_FIRST) && (hCnt <= HS_LAST));
    assign vsyncDec = !((vCnt >= VS_FIRST) && (vCnt <= VS_LAST));

`ifdef VGA_SYNC_DELAY_EN
    logic [1:0] hsPipe;
    logic [1:0] vsPipe;

    // Two-stage sync delay, idle-high so the connector sees inactive sync in reset.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            hsPipe <= '1;
            vsPipe <= '1;
        end else begin
            hsPipe <= {hsPipe[0], hsyncDec};
            vsPipe <= {vsPipe[0], vsyncDec};
        end
    end

    assign vga.hsync = hsPipe[1];
    assign vga.vsync = vsPipe[1];
`else
    assign vga.hsync = hsyncDec;
    assign vga.vsync = vsyncDec;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of vga_timing at default parameters (dutA) and
// a CLK_DIV=1 short-frame build (dutB).
module tb_vga_timing;

`ifdef VGA_SYNC_DELAY_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic clk   = 1'b0;
    logic res_n  = 1'b0;
    logic res_nB = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_if ifA ();
    vga_timing_if ifB ();

    vga_timing dutA (
        .clk   (clk),
        .res_n (res_n),
        .vga   (ifA)
    );

    vga_timing #(
        .CLK_DIV  (1),
        .V_ACTIVE (2),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1)
    ) dutB (
        .clk   (clk),
        .res_n (res_nB),
        .vga   (ifB)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic advance(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Observe n consecutive clk (current sample point first), collecting counts
    // and first indices relative to the window start.
    task automatic window(input int sel, input int n,
                          output int ls, output int fs, output int pe,
                          output int pFirst, output int pLast,
                          output int hLow, output int hFirst,
                          output int vLow, output int vFirst);
        ls = 0; fs = 0; pe = 0; hLow = 0; vLow = 0;
        pFirst = -1; pLast = -1; hFirst = -1; vFirst = -1;
        for (int i = 0; i < n; i++) begin
            logic l, f, p, h, v;
            if (sel == 0) begin
                l = ifA.lineStart; f = ifA.frameStart; p = ifA.pixelEnable;
                h = ifA.hsync;     v = ifA.vsync;
            end else begin
                l = ifB.lineStart; f = ifB.frameStart; p = ifB.pixelEnable;
                h = ifB.hsync;     v = ifB.vsync;
            end
            if (l === 1'b1) ls++;
            if (f === 1'b1) fs++;
            if (p === 1'b1) begin
                pe++;
                if (pFirst < 0) pFirst = i;
                pLast = i;
            end
            if (h === 1'b0) begin
                hLow++;
                if (hFirst < 0) hFirst = i;
            end
            if (v === 1'b0) begin
                vLow++;
                if (vFirst < 0) vFirst = i;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetA(input string tag);
        check({tag, "_x"},  int'(ifA.pixelX), -160);
        check({tag, "_y"},  int'(ifA.pixelY), -45);
        check({tag, "_pe"}, int'(ifA.pixelEnable), 0);
        check({tag, "_ls"}, int'(ifA.lineStart), 1);
        check({tag, "_fs"}, int'(ifA.frameStart), 1);
        check({tag, "_hs"}, int'(ifA.hsync), 1);
        check({tag, "_vs"}, int'(ifA.vsync), 1);
    endtask

    initial begin
        int ls, fs, pe, pFirst, pLast, hLow, hFirst, vLow, vFirst;

        // Both DUTs held in reset.
        #23;
        checkResetA("rstA");
        check("rstB_x",  int'(ifB.pixelX), -160);
        check("rstB_y",  int'(ifB.pixelY), -3);

        // dutB: CLK_DIV=1, 5-line frame (3 blank + 2 active), 800 clk/line.
        @(negedge clk);
        res_nB = 1'b1;
        #1;
        check("B_first_fs", int'(ifB.frameStart), 1);
        window(1, 800, ls, fs, pe, pFirst, pLast, hLow, hFirst, vLow, vFirst);
        check("B_l0_ls", ls, 1);
        check("B_l0_fs", fs, 1);
        check("B_l0_pe", pe, 0);
        check("B_l0_hlow", hLow, 96);
        check("B_l0_hfirst", hFirst, 16 + SD);
        check("B_l0_vlow", vLow, 0);
        window(1, 1600, ls, fs, pe, pFirst, pLast, hLow, hFirst, vLow, vFirst);
        check("B_l12_ls", ls, 2);
        check("B_l12_pe", pe, 0);
        check("B_l12_vlow", vLow, 800);
        check("B_l12_vfirst", vFirst, SD);
        check("B_l3_y", int'(ifB.pixelY), 0);
        window(1, 800, ls, fs, pe, pFirst, pLast, hLow, hFirst, vLow, vFirst);
        check("B_l3_pe", pe, 640);
        check("B_l3_pfirst", pFirst, 160);
        check("B_l3_plast", pLast, 799);
        window(1, 800, ls, fs, pe, pFirst, pLast, hLow, hFirst, vLow, vFirst);
        check("B_l4_pe", pe, 640);
        check("B_wrap_fs", int'(ifB.frameStart), 1);
        check("B_wrap_x", int'(ifB.pixelX), -160);
        check("B_wrap_y", int'(ifB.pixelY), -3);

        // dutA: default timing, 1600 clk/line.
        checkResetA("holdA");
        @(negedge clk);
        res_n = 1'b1;
        #1;
        checkResetA("relA");
        window(0, 1600, ls, fs, pe, pFirst, pLast, hLow, hFirst, vLow, vFirst);
        check("A_l0_ls", ls, 1);
        check("A_l0_fs", fs, 1);
        check("A_l0_pe", pe, 0);
        check("A_l0_hlow", hLow, 192);
        check("A_l0_hfirst", hFirst, 32 + SD);
        check("A_l0_vlow", vLow, 0);
        check("A_l1_ls", int'(ifA.lineStart), 1);
        check("A_l1_fs", int'(ifA.frameStart), 0);
        check("A_l1_x", int'(ifA.pixelX), -160);
        check("A_l1_y", int'(ifA.pixelY), -44);

        advance(14400);
        check("A_l10_y", int'(ifA.pixelY), -35);
        window(0, 3200, ls, fs, pe, pFirst, pLast, hLow, hFirst, vLow, vFirst);
        check("A_vs_ls", ls, 2);
        check("A_vs_hlow", hLow, 384);
        check("A_vs_vlow", vLow, 3200 - SD);
        check("A_vs_vfirst", vFirst, SD);
        check("A_l12_y", int'(ifA.pixelY), -33);

        advance(52800);
        check("A_l45_y", int'(ifA.pixelY), 0);
        check("A_l45_ls", int'(ifA.lineStart), 1);
        window(0, 1600, ls, fs, pe, pFirst, pLast, hLow, hFirst, vLow, vFirst);
        check("A_l45_pe", pe, 640);
        check("A_l45_pfirst", pFirst, 320);
        check("A_l45_plast", pLast, 1598);
        check("A_l45_fs", fs, 0);

        // Mid-line reset inside horizontal sync on a visible row.
        advance(100);
        check("A_mid_x", int'(ifA.pixelX), -110);
        check("A_mid_y", int'(ifA.pixelY), 1);
        check("A_mid_hs", int'(ifA.hsync), 0);
        #2;
        res_n = 1'b0;
        #1;
        checkResetA("asyncA");
        advance(3);
        @(negedge clk);
        res_n = 1'b1;
        #1;
        checkResetA("rel2A");
        window(0, 1600, ls, fs, pe, pFirst, pLast, hLow, hFirst, vLow, vFirst);
        check("A2_l0_ls", ls, 1);
        check("A2_l0_fs", fs, 1);
        check("A2_l0_hlow", hLow, 192);
        check("A2_l0_hfirst", hFirst, 32 + SD);
        check("A2_l1_y", int'(ifA.pixelY), -44);
        check("A2_l1_fs", int'(ifA.frameStart), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
